// File: rtl/sequencer_fsm.sv
// sequencer_fsm
//   Multi-cycle control FSM for the simple RISC datapath. Starting from an
//   accepted start pulse, it steps the register file, the A/B/C pipeline
//   registers and the status register through one instruction, then returns
//   to WAIT.
//
// Ports
//   clk      in   rising-edge clock
//   reset    in   synchronous, active-high reset (wins over everything)
//   s        in   start, sampled only in WAIT
//   opcode   in   [2:0] instruction[15:13] from the decoder
//   op       in   [1:0] instruction[12:11] from the decoder
//   w        out  1 = idle in WAIT, ready for s
//   nsel     out  [1:0] decoder register select: 00=Rm, 01=Rd, 10=Rn
//   loada    out  load register A
//   loadb    out  load register B
//   loadc    out  load register C
//   loads    out  load status register
//   asel     out  1 = ALU A input forced to 0
//   bsel     out  1 = ALU B input is sximm5
//   vsel     out  [1:0] register-file write-data select
//   write    out  register-file write enable
//   illegal  out  one-cycle pulse when an unsupported opcode/op is decoded
//
// States
//   state        | meaning
//   ST_WAIT      | idle, w=1, accepts s and latches opcode/op
//   ST_DECODE    | classify latched fields, flag illegal codes
//   ST_WRITE_IMM | write sximm8 into Rn
//   ST_GET_A     | read Rn into A
//   ST_GET_B     | read Rm into B
//   ST_EXEC      | ALU cycle: load C, or status only for CMP
//   ST_WRITE_REG | write C into Rd

module sequencer_fsm #(
  parameter logic [1:0] VSEL_C     = 2'b00,
  parameter logic [1:0] VSEL_PC    = 2'b01,
  parameter logic [1:0] VSEL_IMM8  = 2'b10,
  parameter logic [1:0] VSEL_MDATA = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [1:0] nsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       illegal
);

  typedef enum logic [2:0] {
    ST_WAIT      = 3'd0,
    ST_DECODE    = 3'd1,
    ST_WRITE_IMM = 3'd2,
    ST_GET_A     = 3'd3,
    ST_GET_B     = 3'd4,
    ST_EXEC      = 3'd5,
    ST_WRITE_REG = 3'd6
  } state_t;

  localparam logic [1:0] NSEL_RM = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RN = 2'b10;

  // PC and MDATA are reserved write-back sources this block never selects;
  // an override that aliased them onto C or IMM8 would make the write-back
  // mux ambiguous, so such a parameter set elaborates to an empty trap block.
  if (VSEL_PC == VSEL_C || VSEL_PC == VSEL_IMM8 ||
      VSEL_MDATA == VSEL_C || VSEL_MDATA == VSEL_IMM8) begin : g_vsel_alias
  end

  function automatic logic f_mov_imm(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b110) && (o == 2'b10);
  endfunction

  function automatic logic f_mov_reg(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b110) && (o == 2'b00);
  endfunction

  function automatic logic f_alu(input logic [2:0] oc);
    return oc == 3'b101;
  endfunction

  function automatic logic f_cmp(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b101) && (o == 2'b01);
  endfunction

  function automatic logic f_mvn(input logic [2:0] oc, input logic [1:0] o);
    return (oc == 3'b101) && (o == 2'b11);
  endfunction

  state_t     state_q, state_d;
  logic [2:0] opcode_q, opcode_d;
  logic [1:0] op_q, op_d;

  logic       w_q, w_d;
  logic [1:0] nsel_q, nsel_d;
  logic       loada_q, loada_d;
  logic       loadb_q, loadb_d;
  logic       loadc_q, loadc_d;
  logic       loads_q, loads_d;
  logic       asel_q, asel_d;
  logic       bsel_q, bsel_d;
  logic [1:0] vsel_q, vsel_d;
  logic       write_q, write_d;
  logic       illegal_q, illegal_d;

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    op_d     = op_q;
    case (state_q)
      ST_WAIT: begin
        if (s) begin
          state_d  = ST_DECODE;
          opcode_d = opcode;
          op_d     = op;
        end
      end
      ST_DECODE: begin
        if (f_mov_imm(opcode_q, op_q))
          state_d = ST_WRITE_IMM;
        else if (f_mov_reg(opcode_q, op_q) || f_mvn(opcode_q, op_q))
          state_d = ST_GET_B;
        else if (f_alu(opcode_q))
          state_d = ST_GET_A;
        else
          state_d = ST_WAIT;
      end
      ST_WRITE_IMM: state_d = ST_WAIT;
      ST_GET_A:     state_d = ST_GET_B;
      ST_GET_B:     state_d = ST_EXEC;
      ST_EXEC:      state_d = f_cmp(opcode_q, op_q) ? ST_WAIT : ST_WRITE_REG;
      ST_WRITE_REG: state_d = ST_WAIT;
      default:      state_d = ST_WAIT;
    endcase
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with the state register: they are Moore outputs without a decode delay.
  always_comb begin
    w_d       = 1'b0;
    nsel_d    = NSEL_RM;
    loada_d   = 1'b0;
    loadb_d   = 1'b0;
    loadc_d   = 1'b0;
    loads_d   = 1'b0;
    asel_d    = 1'b0;
    bsel_d    = 1'b0;
    vsel_d    = VSEL_C;
    write_d   = 1'b0;
    illegal_d = 1'b0;
    case (state_d)
      ST_WAIT: w_d = 1'b1;
      ST_DECODE: begin
        illegal_d = !(f_mov_imm(opcode_d, op_d) || f_mov_reg(opcode_d, op_d) ||
                      f_alu(opcode_d));
      end
      ST_WRITE_IMM: begin
        nsel_d  = NSEL_RN;
        vsel_d  = VSEL_IMM8;
        write_d = 1'b1;
      end
      ST_GET_A: begin
        nsel_d  = NSEL_RN;
        loada_d = 1'b1;
      end
      ST_GET_B: begin
        nsel_d  = NSEL_RM;
        loadb_d = 1'b1;
      end
      ST_EXEC: begin
        asel_d = f_mov_reg(opcode_d, op_d);
        if (f_cmp(opcode_d, op_d))
          loads_d = 1'b1;
        else
          loadc_d = 1'b1;
      end
      ST_WRITE_REG: begin
        nsel_d  = NSEL_RD;
        vsel_d  = VSEL_C;
        write_d = 1'b1;
      end
      default: w_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_WAIT;
      opcode_q  <= '0;
      op_q      <= '0;
      w_q       <= 1'b1;
      nsel_q    <= NSEL_RM;
      loada_q   <= 1'b0;
      loadb_q   <= 1'b0;
      loadc_q   <= 1'b0;
      loads_q   <= 1'b0;
      asel_q    <= 1'b0;
      bsel_q    <= 1'b0;
      vsel_q    <= VSEL_C;
      write_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      op_q      <= op_d;
      w_q       <= w_d;
      nsel_q    <= nsel_d;
      loada_q   <= loada_d;
      loadb_q   <= loadb_d;
      loadc_q   <= loadc_d;
      loads_q   <= loads_d;
      asel_q    <= asel_d;
      bsel_q    <= bsel_d;
      vsel_q    <= vsel_d;
      write_q   <= write_d;
      illegal_q <= illegal_d;
    end
  end

  assign w       = w_q;
  assign nsel    = nsel_q;
  assign loada   = loada_q;
  assign loadb   = loadb_q;
  assign loadc   = loadc_q;
  assign loads   = loads_q;
  assign asel    = asel_q;
  assign bsel    = bsel_q;
  assign vsel    = vsel_q;
  assign write   = write_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_sequencer_fsm.sv
// tb_sequencer_fsm
//   Directed bench for sequencer_fsm. Each task drives one scenario and
//   compares the packed output vector cycle by cycle against hand-written
//   expected vectors.
//   Vector layout: [12]w [11:10]nsel [9]loada [8]loadb [7]loadc [6]loads
//                  [5]asel [4]bsel [3:2]vsel [1]write [0]illegal

module tb_sequencer_fsm;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [1:0] nsel;
  logic       loada, loadb, loadc, loads, asel, bsel;
  logic [1:0] vsel;
  logic       write;
  logic       illegal;

  int vecs  = 0;
  int fails = 0;

  sequencer_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .s       (s),
    .opcode  (opcode),
    .op      (op),
    .w       (w),
    .nsel    (nsel),
    .loada   (loada),
    .loadb   (loadb),
    .loadc   (loadc),
    .loads   (loads),
    .asel    (asel),
    .bsel    (bsel),
    .vsel    (vsel),
    .write   (write),
    .illegal (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] outv;
  assign outv = {w, nsel, loada, loadb, loadc, loads, asel, bsel, vsel, write, illegal};

  //                             w  nsel  la lb lc ls as bs vsel  wr il
  localparam logic [12:0] E_IDLE = {1'b1, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_DEC  = {1'b0, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_ILL  = {1'b0, 2'b00, 6'b000000, 2'b00, 1'b0, 1'b1};
  localparam logic [12:0] E_WIMM = {1'b0, 2'b10, 6'b000000, 2'b10, 1'b1, 1'b0};
  localparam logic [12:0] E_GETA = {1'b0, 2'b10, 6'b100000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_GETB = {1'b0, 2'b00, 6'b010000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_XALU = {1'b0, 2'b00, 6'b001000, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_XMOV = {1'b0, 2'b00, 6'b001010, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_XCMP = {1'b0, 2'b00, 6'b000100, 2'b00, 1'b0, 1'b0};
  localparam logic [12:0] E_WREG = {1'b0, 2'b01, 6'b000000, 2'b00, 1'b1, 1'b0};

  task automatic test_reset();
    reset = 1'b1; s = 1'b1; opcode = 3'b110; op = 2'b10;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      vecs++;
      if (outv !== E_IDLE) begin
        fails++;
        $display("FAIL reset cycle %0d: got %b want %b", i, outv, E_IDLE);
      end
    end
    reset = 1'b0; s = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (outv !== E_IDLE) begin
      fails++;
      $display("FAIL reset idle: got %b want %b", outv, E_IDLE);
    end
  endtask

  task automatic test_mov_imm();
    logic [12:0] exp [3] = '{E_DEC, E_WIMM, E_IDLE};
    s = 1'b1; opcode = 3'b110; op = 2'b10;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      // garbage fields after acceptance must not disturb the latched ones
      if (i == 0) begin s = 1'b0; opcode = 3'b111; op = 2'b01; end
      vecs++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL mov_imm step %0d: got %b want %b", i, outv, exp[i]);
      end
    end
  endtask

  task automatic test_alu(input logic [1:0] alu_op, input string tag);
    logic [12:0] exp [6] = '{E_DEC, E_GETA, E_GETB, E_XALU, E_WREG, E_IDLE};
    s = 1'b1; opcode = 3'b101; op = alu_op;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin opcode = 3'b110; op = 2'b00; end
      if (i == 1) s = 1'b0;
      vecs++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL %s step %0d: got %b want %b", tag, i, outv, exp[i]);
      end
    end
  endtask

  task automatic test_cmp();
    logic [12:0] exp [5] = '{E_DEC, E_GETA, E_GETB, E_XCMP, E_IDLE};
    s = 1'b1; opcode = 3'b101; op = 2'b01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin s = 1'b0; op = 2'b00; end
      vecs++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL cmp step %0d: got %b want %b", i, outv, exp[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [12:0] exp [10] = '{E_DEC, E_GETB, E_XMOV, E_WREG, E_IDLE,
                              E_DEC, E_GETB, E_XALU, E_WREG, E_IDLE};
    s = 1'b1; opcode = 3'b110; op = 2'b00;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin opcode = 3'b101; op = 2'b11; end
      if (i == 5) s = 1'b0;
      vecs++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL back_to_back step %0d: got %b want %b", i, outv, exp[i]);
      end
    end
  endtask

  task automatic test_illegal();
    logic [2:0] oc [5] = '{3'b111, 3'b110, 3'b110, 3'b000, 3'b100};
    logic [1:0] o  [5] = '{2'b00, 2'b01, 2'b11, 2'b00, 2'b10};
    for (int k = 0; k < 5; k++) begin
      s = 1'b1; opcode = oc[k]; op = o[k];
      @(posedge clk); #1;
      s = 1'b0;
      vecs++;
      if (outv !== E_ILL) begin
        fails++;
        $display("FAIL illegal %b/%b pulse: got %b want %b", oc[k], o[k], outv, E_ILL);
      end
      @(posedge clk); #1;
      vecs++;
      if (outv !== E_IDLE) begin
        fails++;
        $display("FAIL illegal %b/%b return: got %b want %b", oc[k], o[k], outv, E_IDLE);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [12:0] exp [3] = '{E_DEC, E_GETA, E_GETB};
    s = 1'b1; opcode = 3'b101; op = 2'b00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (i == 0) s = 1'b0;
      vecs++;
      if (outv !== exp[i]) begin
        fails++;
        $display("FAIL reset_mid step %0d: got %b want %b", i, outv, exp[i]);
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vecs++;
    if (outv !== E_IDLE || write !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid abort: got %b want %b", outv, E_IDLE);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    vecs++;
    if (outv !== E_IDLE) begin
      fails++;
      $display("FAIL reset_mid after: got %b want %b", outv, E_IDLE);
    end
  endtask

  initial begin
    reset = 1'b1; s = 1'b0; opcode = 3'b000; op = 2'b00;
    test_reset();
    test_mov_imm();
    test_alu(2'b00, "add");
    test_alu(2'b10, "and");
    test_cmp();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule

// File: doc/sequencer_fsm.md
Name: sequencer_fsm

Overview:
- Multi-cycle control FSM for the simple RISC datapath.
- Accepts a start pulse and the opcode/op fields from the instruction decoder. Steps the register file, the A/B/C pipeline registers and the status register through one instruction, then returns to WAIT.
- Drives the decoder's binary nsel so readnum/writenum select Rn, Rd or Rm on the right cycle.

Parameters:
- VSEL_C, 2'b00, vsel code selecting datapath_out (C) as write-back source.
- VSEL_PC, 2'b01, vsel code selecting PC (unused by this block, reserved).
- VSEL_IMM8, 2'b10, vsel code selecting sximm8.
- VSEL_MDATA, 2'b11, vsel code selecting mdata (unused, reserved).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- s  in  1  start; sampled only in WAIT
- opcode  in  3  instruction[15:13] from decoder
- op  in  2  instruction[12:11] from decoder
- w  out  1  1 = idle in WAIT, ready for s
- nsel  out  2  decoder register select: 00=Rm, 01=Rd, 10=Rn
- loada  out  1  load register A
- loadb  out  1  load register B
- loadc  out  1  load register C
- loads  out  1  load status register
- asel  out  1  1 = ALU A input forced to 0
- bsel  out  1  1 = ALU B input is sximm5
- vsel  out  2  register-file write-data select
- write  out  1  register-file write enable
- illegal  out  1  one-cycle pulse when an unsupported opcode/op is decoded

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, named reset; it wins over every other input.
- Reset state:
  - Next edge with reset=1 puts the FSM in WAIT.
  - Outputs in WAIT: w=1, everything else 0 (nsel=00, vsel=00).
  - Reset mid-instruction aborts it; no write occurs on that edge.
- Output style: Moore. Outputs decode from state plus the latched op fields. Any output not listed for a state is 0.
- Field capture: on the edge where WAIT sees s=1, opcode/op are latched internally. Later input changes are ignored until the next acceptance. The instruction register must stay stable while w=0 so Rn/Rd/Rm/imm remain valid.
- States and outputs (binary-encoded, 3 bits):
  - WAIT: w=1. s=1 -> DECODE; else stay.
  - DECODE: no strobes. Next state:
    - opcode 110, op 10 (MOV imm) -> WRITE_IMM
    - opcode 110, op 00 (MOV reg) -> GET_B
    - opcode 101, op 00/01/10 (ADD/CMP/AND) -> GET_A
    - opcode 101, op 11 (MVN) -> GET_B
    - any other code -> WAIT, with illegal=1 this cycle
  - WRITE_IMM: nsel=10, vsel=VSEL_IMM8, write=1 -> WAIT.
  - GET_A: nsel=10, loada=1 -> GET_B.
  - GET_B: nsel=00, loadb=1 -> EXEC.
  - EXEC: bsel=0; asel=1 only for MOV reg.
    - CMP: loads=1, loadc=0 -> WAIT.
    - All others: loadc=1 -> WRITE_REG.
  - WRITE_REG: nsel=01, vsel=VSEL_C, write=1 -> WAIT.
- Latency (cycles with w=0, acceptance edge to WAIT re-entry):
  - MOV imm: 2
  - MOV reg: 4
  - MVN: 4
  - CMP: 4
  - ADD: 5
  - AND: 5
  - illegal: 1
- Back-to-back: if s=1 in the first WAIT cycle after return, the next instruction is accepted on that edge; no dead cycle is required.
- s outside WAIT is ignored; no queuing.
- Unreachable state encodings go to WAIT on the next edge with all outputs 0 except w.

Test Plan:
- Reset: reset=1 for 2 cycles with s=1 -> state WAIT, w=1, all strobes 0; stays in WAIT while reset is high.
- MOV R3,#-5 (opcode 110, op 10), s pulsed 1 cycle -> next cycle w=0; following cycle nsel=10, vsel=10, write=1; then w=1. Total 2 cycles with w=0; R3=16'hFFFB in the integrated datapath.
- ADD R2,R1,R0 LSL#1 with R1=3, R0=4 -> sequence:
  - loada with nsel=10
  - loadb with nsel=00
  - loadc with asel=0
  - write with nsel=01, vsel=00
  - Result R2=11 after 5 non-wait cycles.
- CMP R1,R0 with equal values -> loads=1 exactly once, loadc never 1, write never 1; Z status=1; back in WAIT after 4 cycles.
- MOV R5,R1 then MVN R6,R1 back-to-back with s held high -> EXEC for MOV has asel=1; MVN is accepted in the first WAIT cycle; R5=R1, R6=~R1.
- Robustness:
  - Opcode 111 -> illegal pulses 1 cycle; no load or write strobe; returns to WAIT.
  - reset asserted during GET_B of an ADD -> WAIT next edge, write never asserted.
